// File: rtl/cntr_cfg_sequencer.sv
// Job sequencer for the configurable counter: accepts a job, pulses the counter
// restart, watches the indicator under a cycle timeout and returns a status record.
module cntr_cfg_sequencer #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_start,
    input  logic [WIDTH-1:0] cfg_ind,
    input  logic [WIDTH-1:0] cfg_incr,
    input  logic             abort,
    output logic             cntr_rst,
    output logic [WIDTH-1:0] cntr_start,
    output logic [WIDTH-1:0] ind_val,
    output logic [WIDTH-1:0] incr,
    input  logic             ind,
    input  logic [WIDTH-1:0] cntr_out,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             done_hit,
    output logic [7:0]       done_cycles,
    output logic [WIDTH-1:0] done_count
);

    localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_REPORT
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [7:0]       r_cyc;
    logic             r_cfg_ready;
    logic             r_cntr_rst;
    logic [WIDTH-1:0] r_cntr_start;
    logic [WIDTH-1:0] r_ind_val;
    logic [WIDTH-1:0] r_incr;
    logic             r_done_valid;
    logic             r_done_hit;
    logic [7:0]       r_done_cycles;
    logic [WIDTH-1:0] r_done_count;

    logic [7:0]       w_cyc_inc;
    logic             w_accept;
    logic             w_finish;
    logic             w_fin_hit;
    logic [7:0]       w_fin_cycles;

    assign w_cyc_inc = r_cyc + 8'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // r_cyc holds completed RUN cycles, so w_cyc_inc is the number of the current one.
    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_finish     = 1'b0;
        w_fin_hit    = 1'b0;
        w_fin_cycles = r_cyc;
        case (r_state)
            S_IDLE: begin
                if (cfg_valid && r_cfg_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    w_finish     = 1'b1;
                    w_fin_cycles = r_cyc;
                    w_state_nxt  = S_REPORT;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (ind) begin
                    w_finish     = 1'b1;
                    w_fin_hit    = 1'b1;
                    w_fin_cycles = w_cyc_inc;
                    w_state_nxt  = S_REPORT;
                end else if (abort) begin
                    w_finish     = 1'b1;
                    w_fin_cycles = w_cyc_inc;
                    w_state_nxt  = S_REPORT;
                end else if (w_cyc_inc == LP_TIMEOUT) begin
                    w_finish     = 1'b1;
                    w_fin_cycles = LP_TIMEOUT;
                    w_state_nxt  = S_REPORT;
                end
            end
            S_REPORT: begin
                if (r_done_valid && done_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cyc         <= '0;
            r_cfg_ready   <= 1'b0;
            r_cntr_rst    <= 1'b0;
            r_cntr_start  <= '0;
            r_ind_val     <= '0;
            r_incr        <= '0;
            r_done_valid  <= 1'b0;
            r_done_hit    <= 1'b0;
            r_done_cycles <= '0;
            r_done_count  <= '0;
        end else begin
            r_cfg_ready  <= (w_state_nxt == S_IDLE);
            r_cntr_rst   <= (w_state_nxt == S_LOAD);
            r_done_valid <= (w_state_nxt == S_REPORT);
            if (w_accept) begin
                r_cntr_start <= cfg_start;
                r_ind_val    <= cfg_ind;
                r_incr       <= cfg_incr;
                r_cyc        <= '0;
            end else if (r_state == S_RUN) begin
                r_cyc <= w_cyc_inc;
            end
            if (w_finish) begin
                r_done_hit    <= w_fin_hit;
                r_done_cycles <= w_fin_cycles;
                r_done_count  <= cntr_out;
            end
        end
    end

    assign cfg_ready   = r_cfg_ready;
    assign cntr_rst    = r_cntr_rst;
    assign cntr_start  = r_cntr_start;
    assign ind_val     = r_ind_val;
    assign incr        = r_incr;
    assign done_valid  = r_done_valid;
    assign done_hit    = r_done_hit;
    assign done_cycles = r_done_cycles;
    assign done_count  = r_done_count;

endmodule

// File: tb/tb_cntr_cfg_sequencer.sv
// Directed bench for cntr_cfg_sequencer: two instances (TIMEOUT 16 and 4), each
// driving a behavioural counter, with a queue of expected status records.
module tb_cntr_cfg_sequencer;

    typedef struct packed {
        logic       hit;
        logic [7:0] cycles;
        logic [3:0] count;
    } rec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_valid, abort, done_ready, sel;
    logic [3:0] cfg_start, cfg_ind, cfg_incr;

    logic       a_cfg_valid, a_abort, a_done_ready, a_cfg_ready, a_cntr_rst, a_ind;
    logic       a_done_valid, a_done_hit;
    logic [3:0] a_cntr_start, a_ind_val, a_incr, a_cnt, a_done_count;
    logic [7:0] a_done_cycles;

    logic       b_cfg_valid, b_abort, b_done_ready, b_cfg_ready, b_cntr_rst, b_ind;
    logic       b_done_valid, b_done_hit;
    logic [3:0] b_cntr_start, b_ind_val, b_incr, b_cnt, b_done_count;
    logic [7:0] b_done_cycles;

    logic       o_cfg_ready, o_cntr_rst, o_done_valid, o_done_hit;
    logic [3:0] o_cntr_start, o_ind_val, o_incr, o_done_count;
    logic [7:0] o_done_cycles;

    rec_t       sb_q[$];
    logic [11:0] exp_cfg;
    int         nvec = 0;
    int         nerr = 0;

    always #5 clk = ~clk;

    assign a_cfg_valid  = cfg_valid  && !sel;
    assign b_cfg_valid  = cfg_valid  &&  sel;
    assign a_abort      = abort      && !sel;
    assign b_abort      = abort      &&  sel;
    assign a_done_ready = done_ready && !sel;
    assign b_done_ready = done_ready &&  sel;

    assign o_cfg_ready   = sel ? b_cfg_ready   : a_cfg_ready;
    assign o_cntr_rst    = sel ? b_cntr_rst    : a_cntr_rst;
    assign o_cntr_start  = sel ? b_cntr_start  : a_cntr_start;
    assign o_ind_val     = sel ? b_ind_val     : a_ind_val;
    assign o_incr        = sel ? b_incr        : a_incr;
    assign o_done_valid  = sel ? b_done_valid  : a_done_valid;
    assign o_done_hit    = sel ? b_done_hit    : a_done_hit;
    assign o_done_cycles = sel ? b_done_cycles : a_done_cycles;
    assign o_done_count  = sel ? b_done_count  : a_done_count;

    // Behavioural counters standing in for cntr_config.
    always @(posedge clk or negedge reset) begin
        if (!reset)          a_cnt <= 4'd0;
        else if (a_cntr_rst) a_cnt <= a_cntr_start;
        else                 a_cnt <= a_cnt + a_incr;
    end
    assign a_ind = (a_cnt == a_ind_val);

    always @(posedge clk or negedge reset) begin
        if (!reset)          b_cnt <= 4'd0;
        else if (b_cntr_rst) b_cnt <= b_cntr_start;
        else                 b_cnt <= b_cnt + b_incr;
    end
    assign b_ind = (b_cnt == b_ind_val);

    cntr_cfg_sequencer #(.WIDTH(4), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .cfg_valid(a_cfg_valid), .cfg_ready(a_cfg_ready),
        .cfg_start(cfg_start), .cfg_ind(cfg_ind), .cfg_incr(cfg_incr),
        .abort(a_abort), .cntr_rst(a_cntr_rst),
        .cntr_start(a_cntr_start), .ind_val(a_ind_val), .incr(a_incr),
        .ind(a_ind), .cntr_out(a_cnt),
        .done_valid(a_done_valid), .done_ready(a_done_ready),
        .done_hit(a_done_hit), .done_cycles(a_done_cycles), .done_count(a_done_count)
    );

    cntr_cfg_sequencer #(.WIDTH(4), .TIMEOUT(4)) dut_t4 (
        .clk(clk), .reset(reset),
        .cfg_valid(b_cfg_valid), .cfg_ready(b_cfg_ready),
        .cfg_start(cfg_start), .cfg_ind(cfg_ind), .cfg_incr(cfg_incr),
        .abort(b_abort), .cntr_rst(b_cntr_rst),
        .cntr_start(b_cntr_start), .ind_val(b_ind_val), .incr(b_incr),
        .ind(b_ind), .cntr_out(b_cnt),
        .done_valid(b_done_valid), .done_ready(b_done_ready),
        .done_hit(b_done_hit), .done_cycles(b_done_cycles), .done_count(b_done_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // RUN cycle k sees start + (k-1)*incr; stop on hit, abort cycle, or timeout.
    function automatic rec_t model(input logic [3:0] s, input logic [3:0] i,
                                   input logic [3:0] n, input int tmo, input int abort_at);
        rec_t       r;
        logic [3:0] v;
        v = s;
        r = '0;
        for (int k = 1; k <= tmo; k++) begin
            if (v == i) begin
                r.hit = 1'b1; r.cycles = 8'(k); r.count = v;
                return r;
            end
            if (k == abort_at || k == tmo) begin
                r.hit = 1'b0; r.cycles = 8'(k); r.count = v;
                return r;
            end
            v = v + n;
        end
        return r;
    endfunction

    task automatic issue(input logic [3:0] s, input logic [3:0] i, input logic [3:0] n,
                         input int tmo, input int abort_at);
        int w;
        w = 0;
        while (o_cfg_ready !== 1'b1 && w < 50) begin
            @(posedge clk); #1; w++;
        end
        check("cfg_ready_wait", 32'(w < 50), 32'd1);
        cfg_start = s; cfg_ind = i; cfg_incr = n; cfg_valid = 1'b1;
        exp_cfg   = {s, i, n};
        sb_q.push_back(model(s, i, n, tmo, abort_at));
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        cfg_start = ~s; cfg_ind = ~i; cfg_incr = ~n;
        check("load_cntr_rst", 32'(o_cntr_rst), 32'd1);
        check("load_cfg_ready", 32'(o_cfg_ready), 32'd0);
        check("load_cfg_out", 32'({o_cntr_start, o_ind_val, o_incr}), 32'(exp_cfg));
        @(posedge clk); #1;
        check("run_cntr_rst", 32'(o_cntr_rst), 32'd0);
    endtask

    task automatic collect(input int abort_at, input int hold);
        rec_t e;
        int   n;
        n = 0;
        while (o_done_valid !== 1'b1 && n < 300) begin
            abort = (abort_at != 0) && (n + 1 == abort_at);
            @(posedge clk); #1; n++;
        end
        abort = 1'b0;
        check("sb_pending", 32'(sb_q.size()), 32'd1);
        e = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
        check("latency", 32'(n), 32'(e.cycles));
        check("done_hit", 32'(o_done_hit), 32'(e.hit));
        check("done_cycles", 32'(o_done_cycles), 32'(e.cycles));
        check("done_count", 32'(o_done_count), 32'(e.count));
        check("cfg_held", 32'({o_cntr_start, o_ind_val, o_incr}), 32'(exp_cfg));
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(o_done_valid), 32'd1);
            check("hold_record", 32'({o_done_hit, o_done_cycles, o_done_count}), 32'(e));
            check("hold_cfg_ready", 32'(o_cfg_ready), 32'd0);
        end
        done_ready = 1'b1;
        @(posedge clk); #1;
        done_ready = 1'b0;
        check("post_valid", 32'(o_done_valid), 32'd0);
        check("post_cfg_ready", 32'(o_cfg_ready), 32'd1);
    endtask

    initial begin
        reset = 1'b0; cfg_valid = 1'b0; abort = 1'b0; done_ready = 1'b0; sel = 1'b0;
        cfg_start = 4'd0; cfg_ind = 4'd0; cfg_incr = 4'd0;

        #12;
        check("rst_cfg_ready", 32'(o_cfg_ready), 32'd0);
        check("rst_outputs", 32'({o_cntr_rst, o_done_valid, o_done_hit, o_cntr_start,
                                  o_ind_val, o_incr, o_done_cycles, o_done_count}), 32'd0);
        reset = 1'b1;
        #1;
        check("rel_cfg_ready_pre", 32'(o_cfg_ready), 32'd0);
        @(posedge clk); #1;
        check("rel_cfg_ready", 32'(o_cfg_ready), 32'd1);

        // Hit on RUN cycle 5.
        issue(4'd2, 4'd10, 4'd2, 16, 0);
        collect(0, 0);

        // Unreachable indicator: timeout after 16 RUN cycles.
        issue(4'd1, 4'd12, 4'd2, 16, 0);
        collect(0, 0);

        // Requester stalls the record for 5 cycles.
        issue(4'd2, 4'd12, 4'd2, 16, 0);
        collect(0, 5);

        // Abort in RUN cycle 3.
        issue(4'd0, 4'd15, 4'd1, 16, 3);
        collect(3, 0);

        // Abort while idle has no effect.
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("idle_abort_ready", 32'(o_cfg_ready), 32'd1);
        check("idle_abort_valid", 32'(o_done_valid), 32'd0);

        // Indicator already true on RUN cycle 1.
        issue(4'd5, 4'd5, 4'd0, 16, 0);
        collect(0, 0);

        // TIMEOUT=4 instance: hit and timeout coincide, hit wins.
        sel = 1'b1;
        #1;
        issue(4'd0, 4'd3, 4'd1, 4, 0);
        collect(0, 0);
        sel = 1'b0;
        #1;

        // Reset in the middle of RUN.
        issue(4'd0, 4'd15, 4'd1, 16, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        sb_q.delete();
        check("midrst_cfg_ready", 32'(o_cfg_ready), 32'd0);
        check("midrst_outputs", 32'({o_cntr_rst, o_done_valid, o_done_hit, o_cntr_start,
                                     o_ind_val, o_incr, o_done_cycles, o_done_count}), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_rel_ready", 32'(o_cfg_ready), 32'd1);

        issue(4'd2, 4'd10, 4'd2, 16, 0);
        collect(0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
